// File: rtl/booth_r4_seq_mult_pkg.sv
// booth_pkg: FSM states, Booth digit select encoding, digit-count helper (no ports)
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } booth_sel_t;
  function automatic booth_sel_t booth_decode(input logic [2:0] d);
    booth_sel_t s;
    s.zero = (d == 3'b000) || (d == 3'b111);
    s.neg  = d[2];
    s.two  = (d == 3'b011) || (d == 3'b100);
    return s;
  endfunction
  function automatic int ndig(input int w);
    return w / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// booth_r4_seq_mult_if: operand/result handshake bus; master drives in_valid/a/b/is_signed/out_ready, slave drives in_ready/out_valid/result/busy
interface booth_r4_seq_mult_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] result;
  modport master (output in_valid, a, b, is_signed, out_ready, input in_ready, out_valid, result, busy);
  modport slave (input in_valid, a, b, is_signed, out_ready, output in_ready, out_valid, result, busy);
endinterface

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a 3-bit Booth digit and a_ext to the signed multiple {0, +-a, +-2a}; ports dig, a_ext in, mult out
module booth_r4_encoder
  import booth_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic [2:0]              dig,
  input  logic [WIDTH+1:0]        a_ext,
  output logic signed [WIDTH+2:0] mult
);
  booth_sel_t sel;
  logic [WIDTH+2:0] mag;
  always_comb begin
    sel  = booth_decode(dig);
    mag  = sel.two ? {a_ext, 1'b0} : {a_ext[WIDTH+1], a_ext};
    mult = sel.zero ? '0 : sel.neg ? -mag : mag;
  end
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, one digit per clock; ports clk, reset (sync, active-high), bus (slave modport)
module booth_r4_seq_mult
  import booth_pkg::*;
#(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  booth_r4_seq_mult_if.slave bus
);
  localparam int NDIG = ndig(WIDTH);
  localparam int CW = $clog2(NDIG);
  localparam int AW = 2 * WIDTH + 4;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+2:0] b_sh;
  logic [AW-1:0] acc, acc_n;
  logic signed [WIDTH+2:0] mult;
  logic last, accept;
  logic [2*WIDTH-1:0] res;
  booth_r4_encoder #(.WIDTH(WIDTH)) u_enc (.dig(b_sh[2:0]), .a_ext(a_ext), .mult(mult));
  assign last   = cnt == CW'(NDIG - 1);
  assign accept = state == IDLE && bus.in_valid;
  // b_sh shifts right two bits per digit, so the current digit is always b_sh[2:0]
  assign acc_n  = acc + ({{(WIDTH+1){mult[WIDTH+2]}}, mult} << {cnt, 1'b0});
  always_comb begin
    state_n = accept ? RUN
            : (state == RUN && last) ? DONE
            : (state == DONE && bus.out_ready) ? IDLE
            : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      a_ext <= '0;
      b_sh  <= '0;
      res   <= '0;
    end else if (accept) begin
      cnt   <= '0;
      acc   <= '0;
      a_ext <= {{2{bus.a[WIDTH-1] & bus.is_signed}}, bus.a};
      b_sh  <= {{2{bus.b[WIDTH-1] & bus.is_signed}}, bus.b, 1'b0};
    end else if (state == RUN) begin
      cnt  <= cnt + 1'b1;
      acc  <= acc_n;
      b_sh <= b_sh >> 2;
      if (last) res <= acc_n[2*WIDTH-1:0];
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.result    = res;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: directed vector table plus handshake, back-pressure and reset sequences for WIDTH=32
module tb_booth_r4_seq_mult;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  booth_r4_seq_mult_if #(.WIDTH(32)) bus ();
  booth_r4_seq_mult #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.is_signed = s;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = $urandom_range(0, 1);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
  endtask
  task automatic full_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    int lat;
    bus.out_ready = 1'b1;
    start(s, a, b);
    wait_done(lat);
    chk({name, "_latency"}, 64'(lat), 64'd17);
    chk({name, "_result"}, bus.result, p);
    @(posedge clk);
    #1;
    chk({name, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int lat;
    logic [63:0] held, ea, eb;
    vt[0]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vt[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vt[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vt[3]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
    vt[4]  = '{1'b1, 32'h00000003, 32'hFFFFFFF9, 64'hFFFFFFFFFFFFFFEB};
    vt[5]  = '{1'b0, 32'h00000003, 32'hFFFFFFF9, 64'h00000002FFFFFFEB};
    vt[6]  = '{1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000};
    vt[7]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vt[8]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000};
    vt[9]  = '{1'b1, 32'h12345678, 32'h00000002, 64'h000000002468ACF0};
    vt[10] = '{1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF, 64'hFFFFFFFF00000002};
    vt[11] = '{1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000};
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    for (int i = 0; i < 12; i++) full_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].p);
    bus.out_ready = 1'b0;
    start(1'b1, 32'h00000005, 32'hFFFFFFFD);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'd17);
    held = bus.result;
    chk("bp_result", held, 64'hFFFFFFFFFFFFFFF1);
    bus.in_valid = 1'b1;
    bus.a = 32'h0000000B;
    bus.b = 32'h0000000B;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_result", bus.result, held);
      chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("bp_ignored_request_busy", 64'(bus.busy), 64'd0);
    start(1'b0, 32'h00001000, 32'h00001000);
    repeat (5) @(posedge clk);
    #1;
    chk("midrun_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrun_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
    chk("midrun_reset_result", bus.result, 64'd0);
    @(posedge clk);
    #1;
    chk("reset_request_not_accepted", 64'(bus.busy), 64'd0);
    full_op("after_reset", 1'b1, 32'h00000003, 32'hFFFFFFF9, 64'hFFFFFFFFFFFFFFEB);
    bus.out_ready = 1'b0;
    start(1'b0, 32'h00000009, 32'h00000009);
    wait_done(lat);
    chk("done_result", bus.result, 64'd81);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("done_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("done_reset_result", bus.result, 64'd0);
    for (int i = 0; i < 200; i++) begin
      logic s;
      logic [31:0] ra, rb;
      s = $urandom_range(0, 1);
      ra = (i % 8 == 0) ? 32'h80000000 : $urandom;
      rb = (i % 8 == 1) ? 32'hFFFFFFFF : $urandom;
      ea = s ? {{32{ra[31]}}, ra} : {32'd0, ra};
      eb = s ? {{32{rb[31]}}, rb} : {32'd0, rb};
      bus.out_ready = 1'b0;
      start(s, ra, rb);
      wait_done(lat);
      chk("rand_latency", 64'(lat), 64'd17);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("rand_result", bus.result, ea * eb);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
